morse_encoder: RTL and testbench



---
 rtl/morse_encoder.sv | 189 ++++++++++++++++++
 tb/tb_morse_encoder.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/morse_encoder.sv
// Morse transmitter: accepts one character code per valid/ready handshake
// and keys the ITU Morse waveform for it on key_out.
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   char_in      0-25 A-Z, 26-35 digits 0-9, 36 word space, 37-63 ignored
//   char_valid   char_in valid
//   char_ready   encoder idle (combinational from state)
//   key_out      1 = carrier on (mark), registered
//   mark_is_dash 1 while the current mark is a dash, registered
//   busy         high from acceptance until return to idle, registered
module morse_encoder #(
   parameter int unsigned UNIT_CYCLES      = 1000000,
   parameter int unsigned CHAR_GAP_UNITS   = 3,
   parameter int unsigned WORD_EXTRA_UNITS = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] char_in,
   input  logic       char_valid,
   output logic       char_ready,
   output logic       key_out,
   output logic       mark_is_dash,
   output logic       busy
);

   localparam int unsigned CYC_W = $clog2(UNIT_CYCLES);
   localparam logic [CYC_W-1:0] CYC_LAST  = CYC_W'(UNIT_CYCLES - 1);
   localparam logic [2:0]       CGAP_LAST = 3'(CHAR_GAP_UNITS - 1);
   localparam logic [2:0]       WGAP_LAST = 3'(WORD_EXTRA_UNITS - 1);
   localparam logic [5:0]       CODE_WORD = 6'd36;

   typedef enum logic [2:0] {
      S_IDLE,
      S_MARK,
      S_SGAP,
      S_CGAP,
      S_WGAP
   } state_t;

   state_t           state, state_nxt;
   logic [CYC_W-1:0] cyc_cnt, cyc_nxt;
   logic [2:0]       unit_cnt, unit_nxt;
   logic [4:0]       shift_reg, shift_nxt;
   logic [2:0]       rem_cnt, rem_nxt;
   logic [2:0]       unit_last;
   logic             timer_done;
   logic [7:0]       rom_word;
   logic [2:0]       rom_len;
   logic [4:0]       rom_pat;

   // Symbol ROM: {len, pattern}, pattern bit0 = first symbol, 1 = dash; len 0 = no glyph
   always_comb begin
      rom_word = 8'd0;
      case (char_in)
         6'd0:  rom_word = {3'd2, 5'b00010}; // A .-
         6'd1:  rom_word = {3'd4, 5'b00001}; // B -...
         6'd2:  rom_word = {3'd4, 5'b00101}; // C -.-.
         6'd3:  rom_word = {3'd3, 5'b00001}; // D -..
         6'd4:  rom_word = {3'd1, 5'b00000}; // E .
         6'd5:  rom_word = {3'd4, 5'b00100}; // F ..-.
         6'd6:  rom_word = {3'd3, 5'b00011}; // G --.
         6'd7:  rom_word = {3'd4, 5'b00000}; // H ....
         6'd8:  rom_word = {3'd2, 5'b00000}; // I ..
         6'd9:  rom_word = {3'd4, 5'b01110}; // J .---
         6'd10: rom_word = {3'd3, 5'b00101}; // K -.-
         6'd11: rom_word = {3'd4, 5'b00010}; // L .-..
         6'd12: rom_word = {3'd2, 5'b00011}; // M --
         6'd13: rom_word = {3'd2, 5'b00001}; // N -.
         6'd14: rom_word = {3'd3, 5'b00111}; // O ---
         6'd15: rom_word = {3'd4, 5'b00110}; // P .--.
         6'd16: rom_word = {3'd4, 5'b01011}; // Q --.-
         6'd17: rom_word = {3'd3, 5'b00010}; // R .-.
         6'd18: rom_word = {3'd3, 5'b00000}; // S ...
         6'd19: rom_word = {3'd1, 5'b00001}; // T -
         6'd20: rom_word = {3'd3, 5'b00100}; // U ..-
         6'd21: rom_word = {3'd4, 5'b01000}; // V ...-
         6'd22: rom_word = {3'd3, 5'b00110}; // W .--
         6'd23: rom_word = {3'd4, 5'b01001}; // X -..-
         6'd24: rom_word = {3'd4, 5'b01101}; // Y -.--
         6'd25: rom_word = {3'd4, 5'b00011}; // Z --..
         6'd26: rom_word = {3'd5, 5'b11111}; // 0 -----
         6'd27: rom_word = {3'd5, 5'b11110}; // 1 .----
         6'd28: rom_word = {3'd5, 5'b11100}; // 2 ..---
         6'd29: rom_word = {3'd5, 5'b11000}; // 3 ...--
         6'd30: rom_word = {3'd5, 5'b10000}; // 4 ....-
         6'd31: rom_word = {3'd5, 5'b00000}; // 5 .....
         6'd32: rom_word = {3'd5, 5'b00001}; // 6 -....
         6'd33: rom_word = {3'd5, 5'b00011}; // 7 --...
         6'd34: rom_word = {3'd5, 5'b00111}; // 8 ---..
         6'd35: rom_word = {3'd5, 5'b01111}; // 9 ----.
         default: rom_word = 8'd0;
      endcase
   end

   assign rom_len = rom_word[7:5];
   assign rom_pat = rom_word[4:0];

   assign char_ready = (state == S_IDLE);

   // Last unit index of the current state's duration
   always_comb begin
      unit_last = 3'd0;
      case (state)
         S_MARK:  unit_last = shift_reg[0] ? 3'd2 : 3'd0;
         S_SGAP:  unit_last = 3'd0;
         S_CGAP:  unit_last = CGAP_LAST;
         S_WGAP:  unit_last = WGAP_LAST;
         default: unit_last = 3'd0;
      endcase
   end

   assign timer_done = (cyc_cnt == CYC_LAST) && (unit_cnt == unit_last);

   // Next-state, timer and symbol-shift logic
   always_comb begin
      state_nxt = state;
      cyc_nxt   = cyc_cnt;
      unit_nxt  = unit_cnt;
      shift_nxt = shift_reg;
      rem_nxt   = rem_cnt;

      // Timer runs in every timed state and restarts whenever a state ends
      if (state != S_IDLE) begin
         if (timer_done) begin
            cyc_nxt  = '0;
            unit_nxt = 3'd0;
         end else if (cyc_cnt == CYC_LAST) begin
            cyc_nxt  = '0;
            unit_nxt = unit_cnt + 3'd1;
         end else begin
            cyc_nxt = cyc_cnt + CYC_W'(1);
         end
      end

      case (state)
         S_IDLE: begin
            if (char_valid) begin
               if (rom_len != 3'd0) begin
                  state_nxt = S_MARK;
                  shift_nxt = rom_pat;
                  rem_nxt   = rom_len;
               end else if (char_in == CODE_WORD) begin
                  state_nxt = S_WGAP;
               end
            end
         end
         S_MARK: begin
            if (timer_done) begin
               if (rem_cnt > 3'd1) begin
                  state_nxt = S_SGAP;
                  shift_nxt = {1'b0, shift_reg[4:1]};
                  rem_nxt   = rem_cnt - 3'd1;
               end else begin
                  state_nxt = S_CGAP;
               end
            end
         end
         S_SGAP: if (timer_done) state_nxt = S_MARK;
         S_CGAP: if (timer_done) state_nxt = S_IDLE;
         S_WGAP: if (timer_done) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // State, counters and registered outputs (outputs follow the next state)
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= S_IDLE;
         cyc_cnt      <= '0;
         unit_cnt     <= 3'd0;
         shift_reg    <= 5'd0;
         rem_cnt      <= 3'd0;
         key_out      <= 1'b0;
         mark_is_dash <= 1'b0;
         busy         <= 1'b0;
      end else begin
         state        <= state_nxt;
         cyc_cnt      <= cyc_nxt;
         unit_cnt     <= unit_nxt;
         shift_reg    <= shift_nxt;
         rem_cnt      <= rem_nxt;
         key_out      <= (state_nxt == S_MARK);
         mark_is_dash <= (state_nxt == S_MARK) && shift_nxt[0];
         busy         <= (state_nxt != S_IDLE);
      end
   end

endmodule

// File: tb/tb_morse_encoder.sv
// Bench for morse_encoder: directed scenarios plus randomized traffic, all
// checked every cycle against a timeline model built from Morse strings.
module tb_morse_encoder;

   localparam int unsigned U  = 4;
   localparam int unsigned CG = 3;
   localparam int unsigned WE = 4;

   logic       clk;
   logic       rst;
   logic [5:0] char_in;
   logic       char_valid;
   logic       char_ready;
   logic       key_out;
   logic       mark_is_dash;
   logic       busy;

   int checks = 0;
   int errors = 0;

   morse_encoder #(
      .UNIT_CYCLES      (U),
      .CHAR_GAP_UNITS   (CG),
      .WORD_EXTRA_UNITS (WE)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .char_in      (char_in),
      .char_valid   (char_valid),
      .char_ready   (char_ready),
      .key_out      (key_out),
      .mark_is_dash (mark_is_dash),
      .busy         (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: ITU Morse text for codes 0..35
   string morse [36] = '{
      ".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
      "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-",
      "..-", "...-", ".--", "-..-", "-.--", "--..",
      "-----", ".----", "..---", "...--", "....-", ".....", "-....", "--...",
      "---..", "----."
   };

   // Model: per-cycle queue of {key, dash} for the character in flight
   logic [1:0] q[$];
   logic       m_ready   = 1'b1;
   logic       exp_key   = 1'b0;
   logic       exp_dash  = 1'b0;
   logic       exp_busy  = 1'b0;
   logic       exp_ready = 1'b1;
   string      ms;
   int         idx;
   logic       sym_dash;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         q.delete();
         m_ready   = 1'b1;
         exp_key   = 1'b0;
         exp_dash  = 1'b0;
         exp_busy  = 1'b0;
         exp_ready = 1'b1;
      end else begin
         if (m_ready && char_valid) begin
            idx = int'(char_in);
            if (idx < 36) begin
               ms = morse[idx];
               for (int i = 0; i < ms.len(); i++) begin
                  sym_dash = (ms[i] == 8'h2D);
                  for (int k = 0; k < (sym_dash ? 3 : 1) * int'(U); k++) q.push_back({1'b1, sym_dash});
                  if (i < ms.len() - 1)
                     for (int k = 0; k < int'(U); k++) q.push_back(2'b00);
               end
               for (int k = 0; k < int'(CG * U); k++) q.push_back(2'b00);
            end else if (idx == 36) begin
               for (int k = 0; k < int'(WE * U); k++) q.push_back(2'b00);
            end
         end
         if (q.size() > 0) begin
            {exp_key, exp_dash} = q.pop_front();
            exp_busy  = 1'b1;
            exp_ready = 1'b0;
         end else begin
            exp_key   = 1'b0;
            exp_dash  = 1'b0;
            exp_busy  = 1'b0;
            exp_ready = 1'b1;
         end
         m_ready = exp_ready;
      end
   end

   task automatic chk(input string name, input logic got, input logic exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %b, expected %b", name, $time, got, exp);
      end
   endtask

   task automatic lit(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, got, exp);
      end
   endtask

   // Advance to the next falling edge and compare all outputs to the model
   task automatic step();
      @(negedge clk);
      if (rst) begin
         chk("key_out", key_out, exp_key);
         chk("mark_is_dash", mark_is_dash, exp_dash);
         chk("busy", busy, exp_busy);
         chk("char_ready", char_ready, exp_ready);
      end
   endtask

   // Present a code and return at the falling edge after its transfer edge
   task automatic send(input logic [5:0] code, output int waited);
      waited     = 0;
      char_valid = 1'b1;
      char_in    = code;
      while (!char_ready && waited < 300) begin
         step();
         waited++;
      end
      if (!char_ready) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: char_ready=%b after %0d cycles, expected 1", char_ready, waited);
      end
      step();
   endtask

   // Count mark/dash/busy cycles until the encoder is ready again
   task automatic measure(output int hi, output int dsh, output int bsy, output int n);
      hi = 0; dsh = 0; bsy = 0; n = 0;
      while (!char_ready && n < 300) begin
         if (key_out) hi++;
         if (mark_is_dash) dsh++;
         if (busy) bsy++;
         step();
         n++;
      end
      if (!char_ready) begin
         checks++;
         errors++;
         $display("FAIL measure_timeout: char_ready=%b after %0d cycles, expected 1", char_ready, n);
      end
   endtask

   task automatic expect_e(input string tag);
      int w, hi, dsh, bsy, n;
      send(6'd4, w);
      char_valid = 1'b0;
      measure(hi, dsh, bsy, n);
      lit({tag, "_hi"}, hi, 4);
      lit({tag, "_dash"}, dsh, 0);
      lit({tag, "_busy"}, bsy, 16);
      lit({tag, "_ready_at"}, n, 16);
   endtask

   initial begin
      int w, hi, dsh, bsy, n, r;
      logic [5:0] code;

      rst        = 1'b0;
      char_valid = 1'b0;
      char_in    = 6'd0;
      #1;
      lit("rst_key", int'(key_out), 0);
      lit("rst_busy", int'(busy), 0);
      lit("rst_dash", int'(mark_is_dash), 0);
      repeat (3) step();
      rst = 1'b1;
      step();
      lit("ready_after_rst", int'(char_ready), 1);

      // 'E'
      expect_e("E");

      // 'A'
      send(6'd0, w);
      char_valid = 1'b0;
      measure(hi, dsh, bsy, n);
      lit("A_hi", hi, 16);
      lit("A_dash", dsh, 12);
      lit("A_busy", bsy, 32);

      // '0' then 'T' with valid held
      send(6'd26, w);
      send(6'd19, w);
      lit("T_wait_after_0", w, 88);
      char_valid = 1'b0;
      measure(hi, dsh, bsy, n);
      lit("T_hi", hi, 12);
      lit("T_busy", bsy, 24);

      // 'E' then word space
      send(6'd4, w);
      send(6'd36, w);
      lit("W_wait_after_E", w, 16);
      char_valid = 1'b0;
      measure(hi, dsh, bsy, n);
      lit("W_hi", hi, 0);
      lit("W_busy", bsy, 16);

      // Invalid code is consumed silently; next code accepted at once
      send(6'd40, w);
      lit("inv_ready", int'(char_ready), 1);
      lit("inv_busy", int'(busy), 0);
      lit("inv_key", int'(key_out), 0);
      send(6'd4, w);
      lit("inv_next_wait", w, 0);
      char_valid = 1'b0;
      measure(hi, dsh, bsy, n);
      lit("inv_next_busy", bsy, 16);

      // Reset during the 2nd dash of '0'
      send(6'd26, w);
      char_valid = 1'b0;
      repeat (20) step();
      lit("mid_key", int'(key_out), 1);
      lit("mid_dash", int'(mark_is_dash), 1);
      @(posedge clk);
      #2 rst = 1'b0;
      #1;
      lit("abort_key", int'(key_out), 0);
      lit("abort_busy", int'(busy), 0);
      lit("abort_dash", int'(mark_is_dash), 0);
      repeat (2) step();
      rst = 1'b1;
      step();
      expect_e("E_after_abort");

      // Randomized traffic
      for (int it = 0; it < 60; it++) begin
         r = int'($urandom_range(0, 99));
         if (r < 65)      code = 6'($urandom_range(0, 35));
         else if (r < 80) code = 6'd36;
         else             code = 6'($urandom_range(37, 63));
         send(code, w);
         r = int'($urandom_range(0, 99));
         if (r < 40) begin
            // keep valid high: next code goes back-to-back
         end else if (r < 88) begin
            char_valid = 1'b0;
            repeat ($urandom_range(0, 6)) step();
         end else begin
            char_valid = 1'($urandom_range(0, 1));
            repeat ($urandom_range(0, 40)) step();
            @(posedge clk);
            #2 rst = 1'b0;
            #1;
            lit("rand_abort_key", int'(key_out), 0);
            lit("rand_abort_busy", int'(busy), 0);
            step();
            rst = 1'b1;
         end
      end
      char_valid = 1'b0;
      repeat (120) step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
